// File: rtl/clk_div_pkg.sv
// Shared types and capture-time clamping for clk_div_multi (CLK_DIV_MULTI_SYNC_EN adds sync).
// Values pass through 32-bit containers, so any channel width up to 32 uses the same helpers.
package clk_div_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  localparam int unsigned CW = 32;

  function automatic logic [CW-1:0] clamp_div(input logic [CW-1:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  // Expects an already-clamped divisor so the high time always leaves one low cycle.
  function automatic logic [CW-1:0] clamp_high(input logic [CW-1:0] h, input logic [CW-1:0] d);
    if (h == '0) return 32'd1;
    if (h >= d) return d - 32'd1;
    return h;
  endfunction

  function automatic logic [CW-1:0] def_high(input int unsigned d);
    return CW'(d / 2);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow ratio and STOP/RUN FSM; outputs registered, 1-cycle latency.
// Runtime loads while running are deferred to the next wrap (or sync with CLK_DIV_MULTI_SYNC_EN).
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         ena_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] div_i,
  input  logic [W-1:0] high_i,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic         sync_i,
`endif
  output logic         clk_out_o,
  output logic         tick_o,
  output logic         pending_o
);

  chan_state_e  state_q;
  logic [W-1:0] cnt_q, adiv_q, ahigh_q, sdiv_q, shigh_q;
  logic         pend_q, clk_out_q, tick_q;

  logic [W-1:0] cdiv, chigh, cnt_inc, apply_div, apply_high;
  logic         wrap, sync_hit;

  assign cdiv    = W'(clamp_div(32'(div_i)));
  assign chigh   = W'(clamp_high(32'(high_i), 32'(cdiv)));
  assign cnt_inc = cnt_q + 1'b1;
  assign wrap    = (cnt_q == adiv_q - 1'b1);

  // A load in the same cycle as an apply point wins over an older shadow.
  assign apply_div  = load_i ? cdiv  : (pend_q ? sdiv_q  : adiv_q);
  assign apply_high = load_i ? chigh : (pend_q ? shigh_q : ahigh_q);

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign sync_hit = sync_i;
`else
  assign sync_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= STOP;
      cnt_q     <= '0;
      adiv_q    <= W'(DEF_DIV);
      ahigh_q   <= W'(def_high(DEF_DIV));
      sdiv_q    <= W'(DEF_DIV);
      shigh_q   <= W'(def_high(DEF_DIV));
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      case (state_q)
        STOP: begin
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
          tick_q    <= 1'b0;
          pend_q    <= 1'b0;
          if (load_i) begin
            adiv_q  <= cdiv;
            ahigh_q <= chigh;
            sdiv_q  <= cdiv;
            shigh_q <= chigh;
          end
          if (en_i && ena_i) begin
            state_q   <= RUN;
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
          end
        end
        RUN: begin
          if (!en_i || sync_hit || (ena_i && wrap)) begin
            // Every apply point: new ratio takes effect and a fresh period starts (or the channel stops).
            adiv_q    <= apply_div;
            ahigh_q   <= apply_high;
            sdiv_q    <= apply_div;
            shigh_q   <= apply_high;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            clk_out_q <= en_i;
            tick_q    <= en_i;
            if (!en_i) state_q <= STOP;
          end else begin
            tick_q <= 1'b0;
            if (ena_i) begin
              cnt_q     <= cnt_inc;
              clk_out_q <= (cnt_inc < ahigh_q);
            end
            if (load_i) begin
              sdiv_q  <= cdiv;
              shigh_q <= chigh;
              pend_q  <= 1'b1;
            end
          end
        end
        default: state_q <= STOP;
      endcase
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// CH independent programmable dividers sharing ena (and sync under CLK_DIV_MULTI_SYNC_EN).
// Outputs are registered clk-domain levels/pulses, one cycle after the controlling input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CH      = 2,
  parameter int unsigned W       = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ena,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   load,
  input  logic [CH*W-1:0] div,
  input  logic [CH*W-1:0] high,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic            sync,
`endif
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   pending
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    clk_div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_i     (clk),
      .reset_i   (reset),
      .ena_i     (ena),
      .en_i      (en[i]),
      .load_i    (load[i]),
      .div_i     (div[i*W +: W]),
      .high_i    (high[i*W +: W]),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync_i    (sync),
`endif
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .pending_o (pending[i])
    );
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock/tick divider, successor to the fixed even-only divider. Each of `CH` channels divides the system clock by a runtime-loadable ratio (even or odd, ≥2) with programmable high time. It produces a divided level output plus a one-cycle tick per period. The block feeds peripheral timing (UART baud, PWM, display scan) from one system clock, and every output is a registered signal in the `clk` domain, never used as a clock.

## Interface
- `CH`, 2: number of independent channels.
- `W`, 16: divisor/high-time width per channel.
- `DEF_DIV`, 2: active divisor after reset, all channels; must be ≥2 and < 2^W.
- `clk`  in  1: system clock; all logic on posedge.
- `reset`  in  1: reset is synchronous and active-high.
- `ena`  in  1: global advance enable; low freezes all channels.
- `en`  in  CH: per-channel run enable.
- `load`  in  CH: per-channel strobe; captures `div`/`high` slice.
- `div`  in  CH*W: divisor, channel i in bits [i*W +: W].
- `high`  in  CH*W: high time in cycles, same slicing.
- `sync`  in  1: phase restart strobe; present only with the configuration macro.
- `clk_out`  out  CH: divided level.
- `tick`  out  CH: one-cycle pulse at start of each period.
- `pending`  out  CH: shadow values loaded, not yet applied.

## Operation
- Per-channel registers:
  - `cnt[W]`
  - active `adiv`/`ahigh`
  - shadow `sdiv`/`shigh`
  - `pending`
  - state
- Clamp on capture: `div` <2 → 2; `high` 0 → 1; `high` ≥ clamped div → div-1. Clamping is applied in the package function before storage.
- States:
  - STOP: `cnt`=0, `clk_out`=0, `tick`=0.
  - STOP→RUN when `en[i]`=1 and `ena`=1.
  - RUN→STOP when `en[i]`=0, regardless of `ena`.
- In RUN, on each cycle with `ena`=1:
  - `cnt_next` = (`cnt`==`adiv`-1) ? 0 : `cnt`+1.
  - `clk_out` <= (`cnt_next` < `ahigh`).
  - `tick` <= (`cnt_next`==0).
- STOP→RUN entry: `cnt` <= 0, `clk_out` <= 1, `tick` <= 1.
- `ena`=0: `cnt`, `clk_out` and state hold; `tick` <= 0.
- Load while STOP: clamped values go directly to `adiv`/`ahigh`; `pending` stays 0.
- Load while RUN: values go to shadow and `pending` <= 1. At the next wrap (`cnt`==`adiv`-1, `ena`=1), shadow → active and `pending` <= 0. The new ratio governs the period starting at that wrap, so there is no truncated or glitched period.
- Load on the wrap cycle itself: the new values apply at that wrap. `pending` ends 0.
- Repeated loads before a wrap: the last load wins.
- `en` dropped while `pending`: shadow is copied to active on entering STOP; `pending` <= 0.
- Period is `adiv` enabled cycles; high for `ahigh` of them. Odd ratios are exact in period; duty is `ahigh`/`adiv`.

## Timing
- Latency from `en` rise (sampled with `ena`=1) to `clk_out`=1 and `tick`=1: 1 cycle (registered).
- Latency from `en` fall to `clk_out`=0: 1 cycle.
- Reset takes effect at the next posedge with `reset`=1, including mid-period. All channels reset to:
  - STOP, `cnt`=0
  - `adiv`=`DEF_DIV`, `ahigh`=`DEF_DIV`/2, shadow equal to active
  - `clk_out`=0, `tick`=0, `pending`=0
- `reset` overrides `load`, `en` and `sync` in the same cycle.
- Channels are independent; simultaneous events on different channels never interact.

## Configuration
- `CLK_DIV_MULTI_SYNC_EN` defined: the `sync` port exists. On a `sync`=1 cycle, every RUN channel sets `cnt` <= 0, `clk_out` <= 1, `tick` <= 1, and applies pending shadow values. This happens regardless of `ena`. STOP channels ignore `sync`.
- Macro undefined: no `sync` port and no sync logic; behaviour otherwise identical.

## Structure
- Package `clk_div_pkg`:
  - channel state enum (STOP, RUN)
  - `clamp_div`/`clamp_high` functions, parameterised on width
  - default-ratio helper
- Sub-module `clk_div_chan`: one channel (counter, shadow, FSM). Top instantiates `CH` copies with a generate loop and distributes `ena`/`sync`.

## Test plan
- Reset then `en`=1, `ena`=1, default `DEF_DIV`=2 → `clk_out` toggles every cycle; `tick` on every other cycle; `pending`=0.
- Load div=5, high=2 while STOP, then run → `clk_out` pattern 1,1,0,0,0 repeating; `tick` every 5th cycle.
- Running div=4; load div=6, high=3 at `cnt`=1 → current 4-cycle period completes unchanged; `pending`=1 until wrap; next period is 6 cycles, 3 high.
- Load div=0, high=9 → stored 2/1. Then `ena` held low 3 cycles mid-period → outputs frozen, `tick`=0, resumes same phase.
- `reset`=1 mid-period with `pending`=1 → next cycle all outputs 0, `adiv`=`DEF_DIV`, `pending`=0.
- With `CLK_DIV_MULTI_SYNC_EN`: ch0 div=3, ch1 div=7 running out of phase, pulse `sync` → both `tick`=1 next cycle; thereafter ch0 and ch1 ticks coincide every 21 cycles.
